// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage indices, tag/forwarding types and the hazard match helper for the pipeline control slice.
// Latency: none; this package holds types and a pure function only.
// Backpressure: none; the package carries no state.
package pipe_pkg;

  // Stage indices at the nominal 5-stage depth; deeper pipes derive MEM/WB from NSTAGE.
  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  // Tag register width; the top's RADDR_W must not exceed this.
  localparam int PKG_RADDR_W = 5;
  typedef logic [PKG_RADDR_W-1:0] raddr_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic   valid;
    raddr_t rd;
    logic   we;
    logic   is_load;
  } pipe_tag_t;

  // A producer tag hits a source operand only if it really writes a non-x0 register the operand reads.
  function automatic logic tag_hit(input pipe_tag_t t, input raddr_t rs, input logic use_b);
    return t.valid && t.we && (t.rd != '0) && (t.rd == rs) && use_b;
  endfunction

endpackage

// File: rtl/pipe_tag_shift.sv
// pipe_tag_shift: destination-tag shift register for stages EX..WB with per-stage enable and bubble insert.
// Latency: one cycle per stage; a tag moves one stage on each enabled edge.
// Backpressure: a disabled stage holds its tag; flush loads a bubble regardless of enable.
module pipe_tag_shift
  import pipe_pkg::*;
#(
  parameter int NSTAGE = 5
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSTAGE-1:2]        stage_en,
  input  logic [NSTAGE-1:2]        flush,
  input  pipe_tag_t                in_tag,
  output pipe_tag_t [NSTAGE-1:2]   tag
);

  for (genvar s = 2; s < NSTAGE; s++) begin : g_stage
    pipe_tag_t src;
    pipe_tag_t q;

    if (s == 2) begin : g_head
      assign src = in_tag;
    end else begin : g_body
      assign src = tag[s-1];
    end

    // Bubble on flush, shift on enable, otherwise hold the in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)              q <= '0;
      else if (flush[s])    q <= '0;
      else if (stage_en[s]) q <= src;
    end

    assign tag[s] = q;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage enable/valid/flush and forwarding select for the in-order core (build option PIPE_FORWARD_EN).
// Latency: stage control is combinational from ID operands, tag pipe and status; counter and valids are registered.
// Backpressure: mem_busy_i freezes every stage; an unresolved RAW holds IF/ID and injects a bubble into EX.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int RADDR_W  = 5,
  parameter int BR_STAGE = 2,
  parameter int STALL_CW = 16
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_i,
  input  logic [RADDR_W-1:0]  id_rs1_i,
  input  logic [RADDR_W-1:0]  id_rs2_i,
  input  logic [1:0]          id_rs_use_i,
  input  logic [RADDR_W-1:0]  id_rd_i,
  input  logic                id_rd_we_i,
  input  logic                id_is_load_i,
  input  logic                br_taken_i,
  input  logic                mem_busy_i,
  output logic [NSTAGE-1:0]   stage_en_o,
  output logic [NSTAGE-1:0]   stage_valid_o,
  output logic [NSTAGE-1:0]   flush_o,
  output logic [1:0]          fwd_rs1_o,
  output logic [1:0]          fwd_rs2_o,
  output logic [STALL_CW-1:0] stall_cnt_o
);

  logic                   init_q;
  hz_state_e              state_q, state_d;
  pipe_tag_t [NSTAGE-1:2] tags;
  pipe_tag_t              id_tag;
  logic [NSTAGE-1:0]      en_c, fl_c;
  logic [1:0]             v_q;
  logic [2:0]             r1, r2;
  logic                   raw_hz;

  // Per operand: {stall, fwd select}; scanning oldest to youngest lets the youngest producer win.
  function automatic logic [2:0] resolve(input logic [RADDR_W-1:0] rs, input logic use_b,
                                         input pipe_tag_t [NSTAGE-1:2] t);
    logic     stall_b;
    fwd_sel_e f;
    stall_b = 1'b0;
    f       = FWD_RF;
    for (int s = NSTAGE - 1; s >= 2; s--) begin
      if (tag_hit(t[s], raddr_t'(rs), use_b)) begin
`ifdef PIPE_FORWARD_EN
        // Load data is not available before the end of MEM, so a load still ahead of MEM must stall.
        if (t[s].is_load && (s <= NSTAGE - 3)) begin
          stall_b = 1'b1;
          f       = FWD_RF;
        end else begin
          stall_b = 1'b0;
          // A producer in WB writes the register file before ID reads it.
          f = (s == 2) ? FWD_EXMEM : ((s == NSTAGE - 1) ? FWD_RF : FWD_MEMWB);
        end
`else
        stall_b = 1'b1;
        f       = FWD_RF;
`endif
      end
    end
    return {stall_b, f};
  endfunction

  // Holds all outputs at reset values until the first edge after rst releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_q <= 1'b1;
    else     init_q <= 1'b0;
  end

  // Hazard state register; it records the previous cycle's resolved mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next-state; entry and release are combinational, so state_d is also this cycle's mode.
  always_comb begin
    r1     = resolve(id_rs1_i, id_rs_use_i[0], tags);
    r2     = resolve(id_rs2_i, id_rs_use_i[1], tags);
    raw_hz = id_valid_i && (r1[2] || r2[2]);
    state_d = state_q;
    if (init_q) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:      if (mem_busy_i) state_d = MEM_WAIT;
                  else if (!br_taken_i && raw_hz) state_d = STALL;
        STALL:    if (mem_busy_i) state_d = MEM_WAIT;
                  else if (br_taken_i || !raw_hz) state_d = RUN;
        MEM_WAIT: if (!mem_busy_i) state_d = (!br_taken_i && raw_hz) ? STALL : RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Stage enables and flushes for the resolved mode; a taken branch only applies outside busy.
  always_comb begin
    en_c = '1;
    fl_c = '0;
    if (init_q) begin
      en_c = '0;
      fl_c = '1;
    end else begin
      case (state_d)
        MEM_WAIT: en_c = '0;
        STALL: begin
          en_c[ST_ID:ST_IF] = 2'b00;
          fl_c[ST_EX]       = 1'b1;
        end
        default: if (br_taken_i) for (int s = 0; s < BR_STAGE; s++) fl_c[s] = 1'b1;
      endcase
    end
  end

  // A flushed ID is discarded rather than passed into EX.
  always_comb begin
    id_tag.valid   = id_valid_i && !fl_c[ST_ID];
    id_tag.rd      = raddr_t'(id_rd_i);
    id_tag.we      = id_rd_we_i;
    id_tag.is_load = id_is_load_i;
  end

  pipe_tag_shift #(.NSTAGE(NSTAGE)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .stage_en (en_c[NSTAGE-1:2]),
    .flush    (fl_c[NSTAGE-1:2]),
    .in_tag   (id_tag),
    .tag      (tags)
  );

  // IF/ID occupancy: IF always fetches when enabled; ID inherits IF's valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 2'b00;
    end else begin
      if (fl_c[ST_IF])      v_q[0] <= 1'b0;
      else if (en_c[ST_IF]) v_q[0] <= 1'b1;
      if (fl_c[ST_ID])      v_q[1] <= 1'b0;
      else if (en_c[ST_ID]) v_q[1] <= v_q[0];
    end
  end

  // Saturating count of cycles with ID held, excluding the reset window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  stall_cnt_o <= '0;
    else if (!init_q && !en_c[ST_ID] && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
  end

  // Valid view: IF/ID from local flops, EX onward from the tag pipe.
  always_comb begin
    stage_valid_o = '0;
    stage_valid_o[ST_ID:ST_IF] = v_q;
    for (int s = 2; s < NSTAGE; s++) stage_valid_o[s] = tags[s].valid;
  end

  assign stage_en_o = en_c;
  assign flush_o    = fl_c;
  assign fwd_rs1_o  = (init_q || !id_valid_i || raw_hz) ? FWD_RF : r1[1:0];
  assign fwd_rs2_o  = (init_q || !id_valid_i || raw_hz) ? FWD_RF : r2[1:0];

endmodule
